// File: rtl/riscv_pkg.sv
// riscv_pkg: shared MEM-stage constants (XLEN, one-hot memory functs, FSM state encoding)
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [7:0] FUNCT_MEM_LB  = 8'h01;
  localparam logic [7:0] FUNCT_MEM_LH  = 8'h02;
  localparam logic [7:0] FUNCT_MEM_LW  = 8'h04;
  localparam logic [7:0] FUNCT_MEM_LBU = 8'h08;
  localparam logic [7:0] FUNCT_MEM_LHU = 8'h10;
  localparam logic [7:0] FUNCT_MEM_SB  = 8'h20;
  localparam logic [7:0] FUNCT_MEM_SH  = 8'h40;
  localparam logic [7:0] FUNCT_MEM_SW  = 8'h80;
  typedef enum logic [1:0] {S_EMPTY, S_ACCESS, S_FULL} state_t;
endpackage

// File: rtl/riscv_mem_align.sv
// riscv_mem_align: lane replication, byte enables, load extract/extend, misalign detect (i_funct/i_alo/i_wdata/i_rdata -> o_be/o_wdata/o_rdata/o_mis; o_mis live only with RISCV_MEM_MISALIGN_TRAP_EN)
module riscv_mem_align
  import riscv_pkg::*;
(
  input  logic [7:0]  i_funct,
  input  logic [1:0]  i_alo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_mis
);
  logic        w_byte, w_half;
  logic [1:0]  w_lane;
  logic [31:0] w_sh;
  always_comb begin
    w_byte  = |(i_funct & (FUNCT_MEM_LB | FUNCT_MEM_LBU | FUNCT_MEM_SB));
    w_half  = |(i_funct & (FUNCT_MEM_LH | FUNCT_MEM_LHU | FUNCT_MEM_SH));
    w_lane  = w_byte ? i_alo : w_half ? {i_alo[1], 1'b0} : 2'b00;
    o_be    = w_byte ? 4'b0001 << w_lane : w_half ? 4'b0011 << w_lane : 4'b1111;
    o_wdata = w_byte ? {4{i_wdata[7:0]}} : w_half ? {2{i_wdata[15:0]}} : i_wdata;
    w_sh    = i_rdata >> {w_lane, 3'b000};
    o_rdata = i_funct == FUNCT_MEM_LB  ? {{24{w_sh[7]}}, w_sh[7:0]} :
              i_funct == FUNCT_MEM_LBU ? {24'h0, w_sh[7:0]} :
              i_funct == FUNCT_MEM_LH  ? {{16{w_sh[15]}}, w_sh[15:0]} :
              i_funct == FUNCT_MEM_LHU ? {16'h0, w_sh[15:0]} : i_rdata;
`ifdef RISCV_MEM_MISALIGN_TRAP_EN
    o_mis   = (w_half && i_alo[0]) || (|(i_funct & (FUNCT_MEM_LW | FUNCT_MEM_SW)) && i_alo != 2'b00);
`else
    o_mis   = 1'b0;
`endif
  end
endmodule

// File: rtl/riscv_mem.sv
// riscv_mem: MEM stage; EX bundle in (us_rdy/us_ack, ex_mem_*), single-outstanding data bus (dmem_*), WB bundle out (ds_rdy/ds_ack, wb_*); RISCV_MEM_MISALIGN_TRAP_EN turns misaligned accesses into wb_exc traps
module riscv_mem #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            us_rdy,
  output logic            us_ack,
  input  logic [XLEN-1:0] ex_mem_result,
  input  logic [7:0]      ex_mem_funct,
  input  logic [XLEN-1:0] ex_mem_wdata,
  input  logic [RD_W-1:0] ex_mem_rd,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            ds_rdy,
  input  logic            ds_ack,
  output logic [XLEN-1:0] wb_result,
  output logic [RD_W-1:0] wb_rd,
  output logic            wb_we,
  output logic            wb_exc
);
  import riscv_pkg::*;
  state_t          r_state, w_next;
  logic            w_acc, w_mis, w_direct;
  logic [7:0]      r_funct, w_funct;
  logic [1:0]      r_alo, w_alo;
  logic [RD_W-1:0] r_rd;
  logic [3:0]      w_be;
  logic [31:0]     w_wdata, w_rdata;
  assign w_funct = r_state == S_ACCESS ? r_funct : ex_mem_funct;
  assign w_alo   = r_state == S_ACCESS ? r_alo : ex_mem_result[1:0];
  riscv_mem_align u_align (
    .i_funct (w_funct),
    .i_alo   (w_alo),
    .i_wdata (ex_mem_wdata),
    .i_rdata (dmem_rdata),
    .o_be    (w_be),
    .o_wdata (w_wdata),
    .o_rdata (w_rdata),
    .o_mis   (w_mis)
  );
  assign us_ack   = r_state == S_EMPTY || (r_state == S_FULL && ds_ack);
  assign ds_rdy   = r_state == S_FULL;
  assign w_direct = ex_mem_funct == '0 || w_mis;
  always_comb begin
    w_acc  = us_rdy && us_ack;
    w_next = w_acc ? (w_direct ? S_FULL : S_ACCESS) :
             r_state == S_ACCESS && dmem_ack ? S_FULL :
             r_state == S_FULL && ds_ack ? S_EMPTY : r_state;
  end
  always_ff @(posedge clk) r_state <= rst ? S_EMPTY : w_next;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_funct    <= '0;
      r_alo      <= '0;
      r_rd       <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      wb_result  <= '0;
      wb_rd      <= '0;
      wb_we      <= 1'b0;
      wb_exc     <= 1'b0;
    end else if (w_acc) begin
      r_funct    <= ex_mem_funct;
      r_alo      <= ex_mem_result[1:0];
      r_rd       <= ex_mem_rd;
      dmem_req   <= !w_direct;
      dmem_we    <= |ex_mem_funct[7:5] && !w_mis;
      dmem_addr  <= {ex_mem_result[XLEN-1:2], 2'b00};
      dmem_be    <= w_be;
      dmem_wdata <= w_wdata;
      if (w_direct) begin
        wb_result <= ex_mem_result;
        wb_rd     <= ex_mem_rd;
        wb_we     <= ex_mem_rd != '0 && !w_mis;
        wb_exc    <= w_mis;
      end
    end else if (r_state == S_ACCESS && dmem_ack) begin
      dmem_req  <= 1'b0;
      wb_result <= w_rdata;
      wb_rd     <= r_rd;
      wb_we     <= |r_funct[4:0] && r_rd != '0;
      wb_exc    <= 1'b0;
    end
  end
endmodule

// File: tb/tb_riscv_mem.sv
// tb_riscv_mem: directed self-checking bench for the riscv_mem MEM stage
module tb_riscv_mem;
  logic        clk = 1'b0;
  logic        rst, us_rdy, us_ack, dmem_req, dmem_we, dmem_ack, ds_rdy, ds_ack, wb_we, wb_exc;
  logic [31:0] ex_mem_result, ex_mem_wdata, dmem_addr, dmem_wdata, dmem_rdata, wb_result;
  logic [7:0]  ex_mem_funct;
  logic [4:0]  ex_mem_rd, wb_rd;
  logic [3:0]  dmem_be;
  int          n_run = 0, n_fail = 0;
  always #5 clk = ~clk;
  riscv_mem dut (
    .clk(clk), .rst(rst), .us_rdy(us_rdy), .us_ack(us_ack),
    .ex_mem_result(ex_mem_result), .ex_mem_funct(ex_mem_funct),
    .ex_mem_wdata(ex_mem_wdata), .ex_mem_rd(ex_mem_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .ds_rdy(ds_rdy), .ds_ack(ds_ack),
    .wb_result(wb_result), .wb_rd(wb_rd), .wb_we(wb_we), .wb_exc(wb_exc)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [7:0] f, input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
    us_rdy = 1'b1;
    ex_mem_funct = f;
    ex_mem_result = a;
    ex_mem_wdata = d;
    ex_mem_rd = rd;
    tick();
    us_rdy = 1'b0;
  endtask
  initial begin
    rst = 1'b1; us_rdy = 1'b0; ex_mem_result = '0; ex_mem_funct = '0; ex_mem_wdata = '0;
    ex_mem_rd = '0; dmem_ack = 1'b0; dmem_rdata = '0; ds_ack = 1'b1;
    tick(); tick();
    chk("rst_ds_rdy", 32'(ds_rdy), 0);
    chk("rst_req", 32'(dmem_req), 0);
    chk("rst_wb_result", wb_result, 0);
    chk("rst_be", 32'(dmem_be), 0);
    chk("rst_us_ack", 32'(us_ack), 1);
    rst = 1'b0;
    tick();
    // ALU pass-through
    issue(8'h00, 32'h1234_5678, 32'h0, 5'd5);
    chk("pt_ds_rdy", 32'(ds_rdy), 1);
    chk("pt_result", wb_result, 32'h1234_5678);
    chk("pt_we", 32'(wb_we), 1);
    chk("pt_rd", 32'(wb_rd), 5);
    tick();
    chk("pt_pop", 32'(ds_rdy), 0);
    // LB at 0x103, ack on third request cycle
    issue(8'h01, 32'h0000_0103, 32'h0, 5'd7);
    chk("lb_req", 32'(dmem_req), 1);
    chk("lb_addr", dmem_addr, 32'h100);
    chk("lb_be", 32'(dmem_be), 32'b1000);
    chk("lb_we", 32'(dmem_we), 0);
    chk("lb_us_ack", 32'(us_ack), 0);
    tick(); tick();
    chk("lb_req_held", 32'(dmem_req), 1);
    dmem_ack = 1'b1; dmem_rdata = 32'h80FF_0000;
    tick();
    dmem_ack = 1'b0;
    chk("lb_req_drop", 32'(dmem_req), 0);
    chk("lb_ds_rdy", 32'(ds_rdy), 1);
    chk("lb_result", wb_result, 32'hFFFF_FF80);
    chk("lb_we_wb", 32'(wb_we), 1);
    tick();
    // LHU at 0x102
    issue(8'h10, 32'h0000_0102, 32'h0, 5'd8);
    chk("lhu_be", 32'(dmem_be), 32'b1100);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    chk("lhu_result", wb_result, 32'h0000_80FF);
    chk("lhu_rd", 32'(wb_rd), 8);
    tick();
    // LH signed at 0x100
    issue(8'h02, 32'h0000_0100, 32'h0, 5'd2);
    dmem_ack = 1'b1; dmem_rdata = 32'h1234_8001;
    tick();
    dmem_ack = 1'b0;
    chk("lh_result", wb_result, 32'hFFFF_8001);
    tick();
    // SH at 0x202
    issue(8'h40, 32'h0000_0202, 32'hAAAA_BEEF, 5'd9);
    chk("sh_we", 32'(dmem_we), 1);
    chk("sh_be", 32'(dmem_be), 32'b1100);
    chk("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
    chk("sh_addr", dmem_addr, 32'h200);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    chk("sh_ds_rdy", 32'(ds_rdy), 1);
    chk("sh_wb_we", 32'(wb_we), 0);
    tick();
    // SB at 0x201
    issue(8'h20, 32'h0000_0201, 32'h1234_565A, 5'd0);
    chk("sb_be", 32'(dmem_be), 32'b0010);
    chk("sb_wdata", dmem_wdata, 32'h5A5A_5A5A);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    tick();
    // backpressure then back-to-back
    ds_ack = 1'b0;
    issue(8'h00, 32'h1111_1111, 32'h0, 5'd3);
    us_rdy = 1'b1; ex_mem_result = 32'h2222_2222; ex_mem_rd = 5'd4;
    for (int i = 0; i < 4; i++) begin
      chk("bp_us_ack", 32'(us_ack), 0);
      chk("bp_result", wb_result, 32'h1111_1111);
      chk("bp_rd", 32'(wb_rd), 3);
      tick();
    end
    ds_ack = 1'b1;
    #1;
    chk("b2b_us_ack", 32'(us_ack), 1);
    tick();
    us_rdy = 1'b0;
    chk("b2b_ds_rdy", 32'(ds_rdy), 1);
    chk("b2b_result", wb_result, 32'h2222_2222);
    chk("b2b_rd", 32'(wb_rd), 4);
    tick();
    chk("b2b_empty", 32'(ds_rdy), 0);
    // misaligned LW at 0x301
    issue(8'h04, 32'h0000_0301, 32'h0, 5'd10);
`ifdef RISCV_MEM_MISALIGN_TRAP_EN
    chk("mis_req", 32'(dmem_req), 0);
    chk("mis_ds_rdy", 32'(ds_rdy), 1);
    chk("mis_exc", 32'(wb_exc), 1);
    chk("mis_we", 32'(wb_we), 0);
    chk("mis_result", wb_result, 32'h301);
`else
    chk("mis_req", 32'(dmem_req), 1);
    chk("mis_addr", dmem_addr, 32'h300);
    chk("mis_be", 32'(dmem_be), 32'b1111);
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    tick();
    dmem_ack = 1'b0;
    chk("mis_result", wb_result, 32'hCAFE_F00D);
    chk("mis_exc", 32'(wb_exc), 0);
    chk("mis_we", 32'(wb_we), 1);
`endif
    tick();
    // reset during access, late ack ignored
    issue(8'h01, 32'h0000_0400, 32'h0, 5'd1);
    chk("ra_req", 32'(dmem_req), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ra_req_clr", 32'(dmem_req), 0);
    chk("ra_ds_rdy", 32'(ds_rdy), 0);
    chk("ra_result", wb_result, 0);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    chk("ra_late_ds_rdy", 32'(ds_rdy), 0);
    chk("ra_late_req", 32'(dmem_req), 0);
    chk("ra_us_ack", 32'(us_ack), 1);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
